// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame controller driven by an oversample tick
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   rx_meta;
    logic                   rx_s;
    logic [SW-1:0]          s_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   parity_bad;
    logic                   s_mid;
    logic                   s_end;
    logic                   sample_bit;
    logic                   sample_par;
    logic                   deliver;
    logic                   do_ferr;
    logic                   do_perr;
    logic                   par_odd;

    assign s_mid   = (s_cnt == SW'(OVERSAMPLE / 2 - 1));
    assign s_end   = (s_cnt == SW'(OVERSAMPLE - 1));
    assign par_odd = (PARITY_ODD != 0);
    assign busy    = (state != S_IDLE);

    // Two-flop synchronizer for the asynchronous line; idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-tick sampling strobes; nothing moves without a tick
    always_comb begin
        state_nxt  = state;
        sample_bit = 1'b0;
        sample_par = 1'b0;
        deliver    = 1'b0;
        do_ferr    = 1'b0;
        do_perr    = 1'b0;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) state_nxt = S_START;
                end
                S_START: begin
                    if (s_mid) state_nxt = rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (s_end) begin
                        sample_bit = 1'b1;
                        if (bit_cnt == BW'(DATA_BITS - 1))
                            state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (s_end) begin
                        sample_par = 1'b1;
                        state_nxt  = S_STOP;
                    end
                end
                S_STOP: begin
                    if (s_end) begin
                        state_nxt = S_IDLE;
                        if (!rx_s) begin
                            do_ferr   = 1'b1;
                            state_nxt = S_BREAK;
                        end else if (parity_bad) begin
                            do_perr = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Oversample and bit counters: restart on state entry, s_cnt also wraps per bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_cnt   <= '0;
            bit_cnt <= '0;
        end else if (tick) begin
            if (state_nxt != state || s_end) s_cnt <= '0;
            else                             s_cnt <= s_cnt + SW'(1);
            if (state_nxt != state) bit_cnt <= '0;
            else if (sample_bit)    bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Data shift register (LSB arrives first) and parity verdict for the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift      <= '0;
            parity_bad <= 1'b0;
        end else begin
            if (sample_bit) shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (sample_par)
                parity_bad <= ((^shift) ^ rx_s) != par_odd;
            else if (tick && state == S_IDLE)
                parity_bad <= 1'b0;
        end
    end

    // Output word holding register and single-cycle error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= do_ferr;
            parity_err <= do_perr;
            overrun    <= deliver && rx_valid && !rx_ready;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    localparam int TICK_DIV = 8;
    localparam int K_WORD = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;
    localparam int K_OVR  = 3;

    typedef struct {
        int        dut;
        int        kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    int         tick_cnt = 0;

    logic       rx_a = 1'b1;
    logic       rdy_a = 1'b0;
    logic [7:0] data_a;
    logic       valid_a, ferr_a, perr_a, ovr_a, busy_a;

    logic       rx_b = 1'b1;
    logic       rdy_b = 1'b0;
    logic [7:0] data_b;
    logic       valid_b, ferr_b, perr_b, ovr_b, busy_b;

    logic       pv_a = 1'b0, hs_a = 1'b0, pv_b = 1'b0, hs_b = 1'b0;

    exp_t       sb[$];
    int         n_pass = 0;
    int         n_total = 0;

    uart_rx_ctrl u_dut (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_ready(rdy_a),
        .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_ready(rdy_b),
        .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tick_cnt == TICK_DIV - 1) begin
            tick_cnt <= 0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1;
            tick     <= 1'b0;
        end
    end

    // Remember valid/handshake state going into each edge to spot newly presented words
    always @(posedge clk) begin
        pv_a <= valid_a;
        hs_a <= valid_a && rdy_a;
        pv_b <= valid_b;
        hs_b <= valid_b && rdy_b;
    end

    task automatic sb_check(input int dut, input int kind, input logic [7:0] data);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got dut=%0d kind=%0d data=%02h, required no event", dut, kind, data);
        end else begin
            e = sb.pop_front();
            if (e.dut != dut || e.kind != kind || e.data != data)
                $display("FAIL sb_event: got dut=%0d kind=%0d data=%02h, required dut=%0d kind=%0d data=%02h",
                         dut, kind, data, e.dut, e.kind, e.data);
            else
                n_pass++;
        end
    endtask

    // Monitor: every output event is checked against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_a && (!pv_a || hs_a)) sb_check(0, K_WORD, data_a);
            if (ferr_a) sb_check(0, K_FERR, 8'h00);
            if (perr_a) sb_check(0, K_PERR, 8'h00);
            if (ovr_a)  sb_check(0, K_OVR, 8'h00);
            if (valid_b && (!pv_b || hs_b)) sb_check(1, K_WORD, data_b);
            if (ferr_b) sb_check(1, K_FERR, 8'h00);
            if (perr_b) sb_check(1, K_PERR, 8'h00);
            if (ovr_b)  sb_check(1, K_OVR, 8'h00);
        end
    end

    task automatic expect_evt(input int dut, input int kind, input logic [7:0] data);
        exp_t e;
        e.dut = dut; e.kind = kind; e.data = data;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s: got %0h, required %0h", name, act, req);
        else             n_pass++;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (!tick) @(negedge clk);
        end
    endtask

    task automatic set_rx(input int dut, input logic v);
        if (dut == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic send_frame(input int dut, input logic [7:0] d, input bit par_en,
                              input logic par_bit, input logic stop_bit, input int stop_ticks);
        set_rx(dut, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            set_rx(dut, d[i]);
            wait_ticks(16);
        end
        if (par_en) begin
            set_rx(dut, par_bit);
            wait_ticks(16);
        end
        set_rx(dut, stop_bit);
        wait_ticks(stop_ticks);
    endtask

    task automatic consume(input int dut, input string name);
        bit seen = 0;
        for (int i = 0; i < 4000; i++) begin
            if ((dut == 0 && valid_a) || (dut == 1 && valid_b)) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_total++;
            $display("FAIL %s_timeout: rx_valid got 0, required 1", name);
        end else begin
            if (dut == 0) rdy_a = 1'b1; else rdy_b = 1'b1;
            @(negedge clk);
            if (dut == 0) rdy_a = 1'b0; else rdy_b = 1'b0;
            chk({name, "_valid_clear"}, (dut == 0) ? valid_a : valid_b, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", valid_a, 0);
        chk("reset_data", data_a, 8'h00);
        chk("reset_busy", busy_a, 0);
        chk("reset_flags", {ferr_a, perr_a, ovr_a, ferr_b, perr_b, ovr_b}, 0);
        rst = 1'b0;
        wait_ticks(4);

        // 1: clean frame 0xA5
        expect_evt(0, K_WORD, 8'hA5);
        send_frame(0, 8'hA5, 0, 0, 1, 16);
        consume(0, "t1");

        // 2: short low glitch aborts at mid-start
        set_rx(0, 1'b0);
        wait_ticks(3);
        chk("t2_busy_in_start", busy_a, 1);
        wait_ticks(2);
        set_rx(0, 1'b1);
        wait_ticks(12);
        chk("t2_busy_after_glitch", busy_a, 0);
        chk("t2_no_valid", valid_a, 0);

        // 3: stop bit 0 with held-low line, then recovery frame
        expect_evt(0, K_FERR, 8'h00);
        send_frame(0, 8'h3C, 0, 0, 0, 40);
        chk("t3_busy_in_break", busy_a, 1);
        chk("t3_no_valid", valid_a, 0);
        set_rx(0, 1'b1);
        wait_ticks(3);
        chk("t3_busy_released", busy_a, 0);
        expect_evt(0, K_WORD, 8'h81);
        send_frame(0, 8'h81, 0, 0, 1, 16);
        consume(0, "t3");

        // 4: second word while first pending -> overrun, first word kept
        expect_evt(0, K_WORD, 8'h3C);
        send_frame(0, 8'h3C, 0, 0, 1, 16);
        expect_evt(0, K_OVR, 8'h00);
        send_frame(0, 8'hC3, 0, 0, 1, 16);
        chk("t4_data_kept", data_a, 8'h3C);
        consume(0, "t4");

        // 5: even parity, 0x07 needs parity bit 1
        expect_evt(1, K_PERR, 8'h00);
        send_frame(1, 8'h07, 1, 0, 1, 16);
        chk("t5_no_valid", valid_b, 0);
        expect_evt(1, K_WORD, 8'h07);
        send_frame(1, 8'h07, 1, 1, 1, 16);
        consume(1, "t5");

        // 6: reset mid-frame drops a pending word and the frame in flight
        expect_evt(0, K_WORD, 8'h11);
        send_frame(0, 8'h11, 0, 0, 1, 16);
        set_rx(0, 1'b0);
        wait_ticks(16);
        set_rx(0, 1'b1);
        wait_ticks(16 * 4 + 8);
        chk("t6_busy_before_rst", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy_rst", busy_a, 0);
        chk("t6_valid_rst", valid_a, 0);
        chk("t6_data_rst", data_a, 8'h00);
        rst = 1'b0;
        wait_ticks(20);
        expect_evt(0, K_WORD, 8'h5A);
        send_frame(0, 8'h5A, 0, 0, 1, 16);
        consume(0, "t6");

        wait_ticks(20);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
